mem_burst_engine: RTL and testbench

Burst command engine sitting directly upstream of the memory controller's primary interface. Accepts one command (direction, start address, beat count), streams write data in or read data out, and issues one single-beat access per cycle to the controller. Tracks completed write and read beats in saturating counters. Replaces hand-driven per-address stimulus with a reusable synthesizable master.

---
 rtl/mem_burst_pkg.sv | 18 +
 rtl/mem_burst_engine_rd_valid_pipe.sv | 28 ++
 rtl/mem_burst_engine.sv | 159 +++++++++++++++
 tb/tb_mem_burst_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and default sizing for the burst engine.
package mem_burst_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 8;
  localparam int RD_LATENCY_DEF = 2;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_burst_engine_rd_valid_pipe.sv
// Delay line that turns read issues into read-data-valid strobes RD_LATENCY cycles later.
module rd_valid_pipe #(
  parameter int RD_LATENCY = 2
) (
  input  logic clk_i,
  input  logic flush_i,
  input  logic vld_i,
  output logic vld_o,
  output logic empty_o
);

  localparam logic [RD_LATENCY-1:0] OUT_MASK = RD_LATENCY'(1) << (RD_LATENCY - 1);

  logic [RD_LATENCY-1:0] sr_q;

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | RD_LATENCY'(vld_i);
    end
  end

  assign vld_o   = sr_q[RD_LATENCY-1];
  // Empty once nothing is queued behind the beat now at the output stage.
  assign empty_o = ~|(sr_q & ~OUT_MASK);

endmodule

// File: rtl/mem_burst_engine.sv
// Single-command burst master: streams writes in / reads out as one-beat controller accesses.
module mem_burst_engine
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rdata_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_wr_en,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_clr_counts,
  output logic [CNT_WIDTH-1:0]  o_wr_count,
  output logic [CNT_WIDTH-1:0]  o_rd_count
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, rd_cnt_q;
  logic                  rdata_vld;
  logic                  pipe_empty;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    out_addr_d = out_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          addr_d = i_cmd_addr;
          rem_d  = i_cmd_len;
          if (i_cmd_len == '0) begin
            state_d = ST_DONE;
          end else if (i_cmd_wr) begin
            state_d = ST_WRITE;
          end else begin
            // First read is issued straight off the handshake so o_rd_en starts next cycle.
            state_d    = ST_READ;
            rd_en_d    = 1'b1;
            out_addr_d = i_cmd_addr;
            addr_d     = i_cmd_addr + 1'b1;
            rem_d      = i_cmd_len - 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (i_wdata_valid) begin
          wr_en_d    = 1'b1;
          out_addr_d = addr_q;
          wr_data_d  = i_wdata;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (rem_q != '0) begin
          rd_en_d    = 1'b1;
          out_addr_d = addr_q;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      out_addr_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      out_addr_q <= out_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr_counts) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (wr_en_q)   wr_cnt_q <= sat_inc(wr_cnt_q);
      if (rdata_vld) rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  rd_valid_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_valid_pipe (
    .clk_i   (i_clk),
    .flush_i (i_reset),
    .vld_i   (rd_en_q),
    .vld_o   (rdata_vld),
    .empty_o (pipe_empty)
  );

  assign o_cmd_ready   = (state_q == ST_IDLE) && !i_reset;
  assign o_wdata_ready = (state_q == ST_WRITE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_wr_en       = wr_en_q;
  assign o_rd_en       = rd_en_q;
  assign o_address     = out_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_rdata_valid = rdata_vld;
  assign o_rdata       = rdata_vld ? i_rd_data : '0;
  assign o_wr_count    = wr_cnt_q;
  assign o_rd_count    = rd_cnt_q;

endmodule

// File: tb/tb_mem_burst_engine.sv
// Scoreboard bench for mem_burst_engine with a fixed-latency memory model behind it.
module tb_mem_burst_engine;

  localparam int RL = 2;

  logic        i_clk, i_reset;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [7:0]  i_cmd_addr, i_cmd_len;
  logic        i_wdata_valid, o_wdata_ready;
  logic [7:0]  i_wdata;
  logic        o_rdata_valid;
  logic [7:0]  o_rdata;
  logic        o_wr_en, o_rd_en;
  logic [7:0]  o_address, o_wr_data, i_rd_data;
  logic        o_busy, o_done, i_clr_counts;
  logic [15:0] o_wr_count, o_rd_count;

  mem_burst_engine #(
    .DATA_WIDTH (8), .ADDR_WIDTH (8), .LEN_WIDTH (8), .RD_LATENCY (RL), .CNT_WIDTH (16)
  ) dut (
    .i_clk (i_clk), .i_reset (i_reset),
    .i_cmd_valid (i_cmd_valid), .o_cmd_ready (o_cmd_ready), .i_cmd_wr (i_cmd_wr),
    .i_cmd_addr (i_cmd_addr), .i_cmd_len (i_cmd_len),
    .i_wdata_valid (i_wdata_valid), .o_wdata_ready (o_wdata_ready), .i_wdata (i_wdata),
    .o_rdata_valid (o_rdata_valid), .o_rdata (o_rdata),
    .o_wr_en (o_wr_en), .o_rd_en (o_rd_en), .o_address (o_address),
    .o_wr_data (o_wr_data), .i_rd_data (i_rd_data),
    .o_busy (o_busy), .o_done (o_done), .i_clr_counts (i_clr_counts),
    .o_wr_count (o_wr_count), .o_rd_count (o_rd_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks, errors;
  int cyc;
  int hs_cyc, done_cyc, first_rv, last_rv, last_wr_cyc;
  int wr_seen, rd_seen;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  ctrl_mem [256];
  logic [7:0]  rd_pipe [RL];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Controller model: data for a read appears RL cycles after o_rd_en.
  assign i_rd_data = rd_pipe[RL-1];
  always @(posedge i_clk) begin
    if (o_wr_en) ctrl_mem[o_address] <= o_wr_data;
    rd_pipe[0] <= o_rd_en ? ctrl_mem[o_address] : 8'h00;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  always @(negedge i_clk) begin
    logic [15:0] we;
    chk("wr_rd_exclusive", {31'd0, o_wr_en & o_rd_en}, 0);
    if (o_wr_en) begin
      wr_seen++;
      last_wr_cyc = cyc;
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        we = wq.pop_front();
        chk("wr_addr", o_address, we[15:8]);
        chk("wr_data", o_wr_data, we[7:0]);
      end
    end
    if (o_rdata_valid) begin
      rd_seen++;
      if (first_rv < 0) first_rv = cyc;
      last_rv = cyc;
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", o_rdata, rq.pop_front());
    end
  end

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [7:0] l);
    bit ok = 0;
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = a; i_cmd_len = l;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge i_clk);
      if (o_cmd_ready) begin ok = 1; hs_cyc = cyc; end
      else begin @(posedge i_clk); #1; end
    end
    if (!ok) chk("cmd_ready_timeout", 0, 1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge i_clk);
      if (o_done) begin ok = 1; done_cyc = cyc; end
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic do_write(input logic [7:0] a, input int len, input bit gaps,
                          input logic [7:0] d0, input bit clr_last);
    logic [7:0] addr = a;
    send_cmd(1'b1, a, 8'(len));
    for (int b = 0; b < len; b++) begin
      bit ok = 0;
      if (gaps && (b % 2 == 1)) begin
        i_wdata_valid = 1'b0;
        @(posedge i_clk); #1;
      end
      i_wdata_valid = 1'b1;
      i_wdata = d0 + 8'(b);
      for (int k = 0; k < 64 && !ok; k++) begin
        @(negedge i_clk);
        if (o_wdata_ready) ok = 1;
        else begin @(posedge i_clk); #1; end
      end
      if (!ok) chk("wdata_ready_timeout", 0, 1);
      wq.push_back({addr, i_wdata});
      ref_mem[addr] = i_wdata;
      addr = addr + 8'd1;
      @(posedge i_clk); #1;
    end
    i_wdata_valid = 1'b0;
    if (clr_last) i_clr_counts = 1'b1;
    wait_done();
    i_clr_counts = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input int len);
    send_cmd(1'b0, a, 8'(len));
    for (int b = 0; b < len; b++) rq.push_back(ref_mem[8'(a + 8'(b))]);
    wait_done();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int rs;
    checks = 0; errors = 0; first_rv = -1;
    wr_seen = 0; rd_seen = 0;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wdata_valid = 1'b0; i_wdata = '0; i_clr_counts = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_en", {o_wr_en, o_rd_en, o_rdata_valid, o_done}, 0);
    chk("rst_counts", {o_wr_count, o_rd_count}, 0);
    i_reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", o_cmd_ready, 1);
    @(posedge i_clk); #1;

    // Continuous write burst, then read it back
    do_write(8'h10, 4, 1'b0, 8'hA0, 1'b0);
    chk("wr_last_with_done", last_wr_cyc, done_cyc);
    chk("wr_count_4", o_wr_count, 16'd4);
    chk("wr_beats_4", wr_seen, 4);
    first_rv = -1;
    do_read(8'h10, 4);
    chk("rd_first_lat", first_rv - hs_cyc, 3);
    chk("rd_last_lat", last_rv - hs_cyc, 6);
    chk("rd_done_lat", done_cyc - hs_cyc, 7);
    chk("rd_count_4", o_rd_count, 16'd4);

    // Wrapping write with data gaps, read back across the wrap
    do_write(8'hFE, 4, 1'b1, 8'hB0, 1'b0);
    chk("wr_count_8", o_wr_count, 16'd8);
    chk("wr_beats_8", wr_seen, 8);
    do_read(8'hFE, 4);
    chk("rd_count_8", o_rd_count, 16'd8);

    // Zero-length commands, back to back
    send_cmd(1'b1, 8'h33, 8'd0);
    rs = hs_cyc;
    wait_done();
    chk("len0_done_lat", done_cyc - rs, 1);
    send_cmd(1'b0, 8'h44, 8'd0);
    chk("b2b_accept", hs_cyc - done_cyc, 1);
    wait_done();
    chk("len0_counts", {o_wr_count, o_rd_count}, {16'd8, 16'd8});
    chk("len0_no_access", wr_seen + rd_seen, 16);

    // Reset during beat 2 of an 8-beat read
    rs = rd_seen;
    send_cmd(1'b0, 8'h10, 8'd8);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("midrst_cmd_ready", o_cmd_ready, 0);
    chk("midrst_ctrl", {o_busy, o_done, o_wr_en, o_rd_en, o_rdata_valid, o_wdata_ready}, 0);
    chk("midrst_bus", {o_address, o_wr_data, o_rdata}, 0);
    chk("midrst_counts", {o_wr_count, o_rd_count}, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    chk("midrst_ready_after", o_cmd_ready, 1);
    repeat (6) @(posedge i_clk);
    #1;
    chk("midrst_no_rvalid", rd_seen, rs);

    // Clear coincident with a write strobe
    do_read(8'h10, 2);
    chk("rd_count_2", o_rd_count, 16'd2);
    do_write(8'h20, 3, 1'b0, 8'hC0, 1'b0);
    chk("wr_count_3", o_wr_count, 16'd3);
    do_write(8'h30, 1, 1'b0, 8'hD0, 1'b1);
    chk("clr_wins_wr", o_wr_count, 16'd0);
    chk("clr_rd", o_rd_count, 16'd0);

    // Saturation: 257 bursts of 255 beats reach exactly all-ones
    for (int b = 0; b < 257; b++) do_write(8'(b * 3), 255, 1'b0, 8'(b), 1'b0);
    chk("wr_count_full", o_wr_count, 16'hFFFF);
    do_write(8'h50, 2, 1'b0, 8'hE0, 1'b0);
    chk("wr_count_sat", o_wr_count, 16'hFFFF);

    repeat (4) @(posedge i_clk);
    #1;
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
